pool_cu_gen: RTL and testbench
==============================

Name: pool_cu_gen

Overview:
- Generalised pooling control unit, successor to the fixed 2x2/stride-2 pool CU.
- Walks every pooling window explicitly, so any KERNEL_SIZE/STRIDE combination works, including overlapping windows (STRIDE < KERNEL_SIZE).
- Issues one IFM read per cycle and emits window-boundary strobes to the max/avg datapath. Sets the pool mode per frame.
- Sits between the previous layer's ping-pong IFM memory and the next layer's ping-pong memory, using the start/end handshake and frame-level back-pressure.

Parameters:
IFM_SIZE, 28, input feature-map side length
KERNEL_SIZE, 2, pooling window side (K)
STRIDE, 2, window step (S); 1 <= S <= K
RD_LAT, 1, IFM memory read latency in cycles (1..4)
OFM_SIZE, (IFM_SIZE-KERNEL_SIZE)/STRIDE+1, output side length (derived)
ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), read address width (derived)
ADDRESS_SIZE_NEXT_IFM, $clog2(OFM_SIZE*OFM_SIZE), write address width (derived)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start_from_previous  input  1  previous layer has a frame ready (level)
pool_mode_in  input  1  0 = max, 1 = average; sampled when a frame starts
end_from_next  input  1  next layer has finished consuming its buffer (level)
end_to_previous  output  1  high when the CU is not reading a frame
ifm_enable_read  output  1  IFM read enable
ifm_address_read  output  ADDRESS_SIZE_IFM  IFM read address
pool_first  output  1  data on the memory bus is the first element of a window
pool_last  output  1  data on the memory bus is the last element of a window
pool_mode  output  1  latched mode for the current frame
ifm_enable_write_next  output  1  write strobe for one pooled result
ifm_address_write_next  output  ADDRESS_SIZE_NEXT_IFM  write address into the next memory
start_to_next  output  1  one-cycle pulse: a full frame is available to the next layer
ifm_sel_next  output  1  ping-pong buffer select for the next layer

Behaviour:
- Reset (reset=0, asynchronous) clears all outputs, counters and the pending flag to 0. end_to_previous resets to 1. State resets to IDLE. Reset mid-frame abandons the frame; no start_to_next is issued.
- Counters: oy, ox in 0..OFM_SIZE-1; ky, kx in 0..K-1. Nested order, innermost first: kx, ky, ox, oy.
- Address: ifm_address_read = (oy*S+ky)*IFM_SIZE + ox*S + kx. Computed from registered row/column bases; multiplies are not on the critical path.
- FSM states: IDLE, READ, DRAIN, HOLD.
  - IDLE: end_to_previous=1. If start_from_previous=1 and pending=0 -> READ, latching pool_mode_in. If start_from_previous=1 and pending=1 -> HOLD.
  - HOLD: end_to_previous=1, no reads. When pending clears -> READ, latching the mode.
  - READ: ifm_enable_read=1, end_to_previous=0, one address per cycle. After the last address (oy=ox=OFM_SIZE-1, ky=kx=K-1) -> DRAIN.
  - DRAIN: wait RD_LAT+1 cycles for the final write, then set pending=1 and go to IDLE.
- Strobe timing: pool_first/pool_last are the kx=ky=0 and kx=ky=K-1 conditions, delayed RD_LAT cycles so they align with the read data.
- Write: ifm_enable_write_next = pool_last delayed 1 cycle, i.e. RD_LAT+1 after the last address. The datapath registers its result in that cycle.
- ifm_address_write_next increments after each write and wraps to 0 after OFM_SIZE*OFM_SIZE-1.
- Handoff: while pending=1 and end_from_next=1, pulse start_to_next for one cycle, toggle ifm_sel_next on the following edge, and clear pending.
  - If the pulse coincides with the IDLE->HOLD check, HOLD lasts one cycle.
- Throughput: OFM_SIZE^2*K^2 read cycles per frame, with no bubbles inside a frame.
- start_from_previous during READ or DRAIN is ignored.

Test Plan:
- IFM=4, K=2, S=2, RD_LAT=1, end_from_next=1: addresses 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15 on consecutive cycles. Exactly 4 writes at addresses 0..3, the first 2 cycles after address 5. One start_to_next pulse, then ifm_sel_next=1.
- IFM=5, K=3, S=1: first window 0,1,2,5,6,7,10,11,12; second window 1,2,3,6,7,8,11,12,13. 81 read cycles, 9 writes, pool_first/pool_last each asserted 9 times.
- pool_mode_in=1 at start, toggled to 0 mid-frame: pool_mode stays 1 all frame. The next frame latches 0.
- Back-pressure: end_from_next=0 at frame end with start_from_previous held: pending=1, FSM in HOLD, no reads, no start_to_next. Raising end_from_next gives one start_to_next pulse, a select toggle, and reads restarting at address 0.
- reset=0 mid-READ (e.g. after 7 addresses): all outputs 0 immediately, end_to_previous=1. After release, a new frame restarts at address 0 and write address 0.
- RD_LAT=3: write strobe 4 cycles after each window's last address. ifm_address_write_next wraps 15->0 across two frames (IFM=8, K=2, S=2).

Source files
------------

// File: rtl/pool_cu_gen.sv
// pool_cu_gen: generalised pooling control unit walking every KxK window with stride S over the IFM
module pool_cu_gen #(
  parameter int IFM_SIZE              = 28,
  parameter int KERNEL_SIZE           = 2,
  parameter int STRIDE                = 2,
  parameter int RD_LAT                = 1,
  parameter int OFM_SIZE              = (IFM_SIZE - KERNEL_SIZE) / STRIDE + 1,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(OFM_SIZE * OFM_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  input  logic                             pool_mode_in,
  input  logic                             end_from_next,
  output logic                             end_to_previous,
  output logic                             ifm_enable_read,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read,
  output logic                             pool_first,
  output logic                             pool_last,
  output logic                             pool_mode,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             start_to_next,
  output logic                             ifm_sel_next
);
  localparam int AW = ADDRESS_SIZE_IFM;
  localparam int NW = ADDRESS_SIZE_NEXT_IFM;
  localparam int CW = $clog2(IFM_SIZE + 1);
  localparam logic [CW-1:0] KMAX = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] OMAX = CW'(OFM_SIZE - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IFM_SIZE);
  localparam logic [AW-1:0] OY_STEP = AW'(STRIDE * IFM_SIZE);
  localparam logic [AW-1:0] OX_STEP = AW'(STRIDE);
  localparam logic [NW-1:0] WMAX = NW'(OFM_SIZE * OFM_SIZE - 1);
  localparam logic [2:0] DMAX = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

  state_t state;
  logic [CW-1:0] kx, ky, ox, oy;
  logic [AW-1:0] oy_row, ky_row, ox_col;
  logic [2:0] dcnt;
  logic pending;
  logic [RD_LAT-1:0] first_sr, last_sr;
  logic k_end, win_end, row_end, frame_end;

  assign k_end     = kx == KMAX;
  assign win_end   = k_end && ky == KMAX;
  assign row_end   = win_end && ox == OMAX;
  assign frame_end = row_end && oy == OMAX;

  // row/column bases are kept as running sums so the address is a plain add
  assign ifm_address_read = oy_row + ky_row + ox_col + AW'(kx);
  assign pool_first       = first_sr[RD_LAT-1];
  assign pool_last        = last_sr[RD_LAT-1];

  // frame sequencing, window walk, drain timing and next-layer handoff
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      kx              <= '0;
      ky              <= '0;
      ox              <= '0;
      oy              <= '0;
      oy_row          <= '0;
      ky_row          <= '0;
      ox_col          <= '0;
      dcnt            <= '0;
      pending         <= 1'b0;
      pool_mode       <= 1'b0;
      ifm_enable_read <= 1'b0;
      end_to_previous <= 1'b1;
      start_to_next   <= 1'b0;
      ifm_sel_next    <= 1'b0;
    end else begin
      start_to_next <= pending && end_from_next;
      if (start_to_next) ifm_sel_next <= !ifm_sel_next;
      if (pending && end_from_next) pending <= 1'b0;
      case (state)
        IDLE: if (start_from_previous) begin
          state <= pending ? HOLD : READ;
          if (!pending) begin
            ifm_enable_read <= 1'b1;
            end_to_previous <= 1'b0;
            pool_mode       <= pool_mode_in;
          end
        end
        HOLD: if (!pending) begin
          state           <= READ;
          ifm_enable_read <= 1'b1;
          end_to_previous <= 1'b0;
          pool_mode       <= pool_mode_in;
        end
        READ: begin
          kx <= k_end ? '0 : kx + 1'b1;
          if (k_end) ky <= ky == KMAX ? '0 : ky + 1'b1;
          if (k_end) ky_row <= ky == KMAX ? '0 : ky_row + ROW_STEP;
          if (win_end) ox <= ox == OMAX ? '0 : ox + 1'b1;
          if (win_end) ox_col <= ox == OMAX ? '0 : ox_col + OX_STEP;
          if (row_end) oy <= oy == OMAX ? '0 : oy + 1'b1;
          if (row_end) oy_row <= oy == OMAX ? '0 : oy_row + OY_STEP;
          if (frame_end) begin
            state           <= DRAIN;
            ifm_enable_read <= 1'b0;
            end_to_previous <= 1'b1;
          end
        end
        DRAIN: begin
          dcnt <= dcnt == DMAX ? '0 : dcnt + 1'b1;
          if (dcnt == DMAX) begin
            pending <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // window strobes follow the read data through the memory latency; write one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_sr               <= '0;
      last_sr                <= '0;
      ifm_enable_write_next  <= 1'b0;
      ifm_address_write_next <= '0;
    end else begin
      first_sr               <= RD_LAT'({first_sr, state == READ && kx == '0 && ky == '0});
      last_sr                <= RD_LAT'({last_sr, state == READ && win_end});
      ifm_enable_write_next  <= last_sr[RD_LAT-1];
      if (ifm_enable_write_next)
        ifm_address_write_next <= ifm_address_write_next == WMAX ? '0 : ifm_address_write_next + 1'b1;
    end
  end
endmodule

// File: tb/tb_pool_cu_gen.sv
// tb_pool_cu_gen: three pool CU configurations checked against a window-walk reference model
module tb_pool_cu_gen;
  localparam int P_IFM [3] = '{4, 5, 8};
  localparam int P_K   [3] = '{2, 3, 2};
  localparam int P_S   [3] = '{2, 1, 2};
  localparam int P_L   [3] = '{1, 3, 3};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic st [3], mi [3], efn [3];
  logic etp [3], rd [3], pf [3], pl [3], pm [3], we [3], stn [3], sel [3];
  logic [3:0] ra0;
  logic [4:0] ra1;
  logic [5:0] ra2;
  logic [1:0] wa0;
  logic [3:0] wa1, wa2;

  int vec = 0, bad = 0, cyc = 0;
  int rn [3] = '{0, 0, 0};
  int fn [3] = '{0, 0, 0};
  int ln [3] = '{0, 0, 0};
  int wn [3] = '{0, 0, 0};
  int sn [3] = '{0, 0, 0};
  int radr [3][1024];
  int rcyc [3][1024];
  int rmode [3][1024];
  int fcyc [3][128];
  int lcyc [3][128];
  int wcyc [3][128];
  int wadr [3][128];
  int scyc [3][128];
  int br, bf, bl, bw, bs;
  int pulses [3] = '{0, 0, 0};
  int m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_cu_gen #(.IFM_SIZE(4), .KERNEL_SIZE(2), .STRIDE(2), .RD_LAT(1)) u0 (
    .clk(clk), .reset(reset), .start_from_previous(st[0]), .pool_mode_in(mi[0]),
    .end_from_next(efn[0]), .end_to_previous(etp[0]), .ifm_enable_read(rd[0]),
    .ifm_address_read(ra0), .pool_first(pf[0]), .pool_last(pl[0]), .pool_mode(pm[0]),
    .ifm_enable_write_next(we[0]), .ifm_address_write_next(wa0),
    .start_to_next(stn[0]), .ifm_sel_next(sel[0]));

  pool_cu_gen #(.IFM_SIZE(5), .KERNEL_SIZE(3), .STRIDE(1), .RD_LAT(3)) u1 (
    .clk(clk), .reset(reset), .start_from_previous(st[1]), .pool_mode_in(mi[1]),
    .end_from_next(efn[1]), .end_to_previous(etp[1]), .ifm_enable_read(rd[1]),
    .ifm_address_read(ra1), .pool_first(pf[1]), .pool_last(pl[1]), .pool_mode(pm[1]),
    .ifm_enable_write_next(we[1]), .ifm_address_write_next(wa1),
    .start_to_next(stn[1]), .ifm_sel_next(sel[1]));

  pool_cu_gen #(.IFM_SIZE(8), .KERNEL_SIZE(2), .STRIDE(2), .RD_LAT(3)) u2 (
    .clk(clk), .reset(reset), .start_from_previous(st[2]), .pool_mode_in(mi[2]),
    .end_from_next(efn[2]), .end_to_previous(etp[2]), .ifm_enable_read(rd[2]),
    .ifm_address_read(ra2), .pool_first(pf[2]), .pool_last(pl[2]), .pool_mode(pm[2]),
    .ifm_enable_write_next(we[2]), .ifm_address_write_next(wa2),
    .start_to_next(stn[2]), .ifm_sel_next(sel[2]));

  // event logger: every strobe of every instance with the cycle it was seen in
  always @(negedge clk) begin
    int a, w;
    for (int id = 0; id < 3; id++) begin
      a = id == 0 ? int'(ra0) : id == 1 ? int'(ra1) : int'(ra2);
      w = id == 0 ? int'(wa0) : id == 1 ? int'(wa1) : int'(wa2);
      if (rd[id] && rn[id] < 1024) begin
        radr[id][rn[id]] = a;
        rcyc[id][rn[id]] = cyc;
        rmode[id][rn[id]] = int'(pm[id]);
        rn[id]++;
      end
      if (pf[id] && fn[id] < 128) begin fcyc[id][fn[id]] = cyc; fn[id]++; end
      if (pl[id] && ln[id] < 128) begin lcyc[id][ln[id]] = cyc; ln[id]++; end
      if (we[id] && wn[id] < 128) begin wcyc[id][wn[id]] = cyc; wadr[id][wn[id]] = w; wn[id]++; end
      if (stn[id] && sn[id] < 128) begin scyc[id][sn[id]] = cyc; sn[id]++; end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap(input int id);
    br = rn[id]; bf = fn[id]; bl = ln[id]; bw = wn[id]; bs = sn[id];
  endtask

  task automatic wait_read(input int id);
    int t = 0;
    while (!rd[id] && t < 300) begin @(negedge clk); t++; end
    #1;
    chk("wait_read", int'(rd[id]), 1);
  endtask

  task automatic wait_done(input int id);
    int t = 0;
    while (!etp[id] && t < 2000) begin @(negedge clk); t++; end
    chk("wait_done", int'(etp[id]), 1);
    cycles(P_L[id] + 8);
  endtask

  task automatic run_frame(input int id, input int mode, input int mode_after);
    st[id] = 1'b1;
    mi[id] = mode[0];
    wait_read(id);
    st[id] = 1'b0;
    mi[id] = mode_after[0];
    wait_done(id);
  endtask

  // reference: nested window walk straight from the address formula and latency rules
  task automatic frame_check(input int id, input int mode);
    int ifm, k, s, lat, ofm, nw, j;
    ifm = P_IFM[id]; k = P_K[id]; s = P_S[id]; lat = P_L[id];
    ofm = (ifm - k) / s + 1;
    nw = ofm * ofm;
    j = 0;
    chk("read_count", rn[id] - br, nw * k * k);
    chk("first_count", fn[id] - bf, nw);
    chk("last_count", ln[id] - bl, nw);
    chk("write_count", wn[id] - bw, nw);
    for (int oy = 0; oy < ofm; oy++)
      for (int ox = 0; ox < ofm; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            if (br + j < rn[id]) begin
              chk("read_addr", radr[id][br + j], (oy * s + ky) * ifm + ox * s + kx);
              chk("read_cycle", rcyc[id][br + j] - rcyc[id][br], j);
              chk("pool_mode", rmode[id][br + j], mode);
            end
            j++;
          end
    for (int w = 0; w < nw; w++) begin
      int r0, r1;
      r0 = br + w * k * k;
      r1 = r0 + k * k - 1;
      if (r1 < rn[id] && bf + w < fn[id] && bl + w < ln[id] && bw + w < wn[id]) begin
        chk("first_cycle", fcyc[id][bf + w], rcyc[id][r0] + lat);
        chk("last_cycle", lcyc[id][bl + w], rcyc[id][r1] + lat);
        chk("write_cycle", wcyc[id][bw + w], rcyc[id][r1] + lat + 1);
        chk("write_addr", wadr[id][bw + w], w);
      end
    end
  endtask

  task automatic handoff(input int id);
    pulses[id]++;
    chk("pulse_count", sn[id] - bs, 1);
    if (sn[id] > bs && wn[id] > 0) chk("pulse_cycle", scyc[id][bs], wcyc[id][wn[id] - 1] + 2);
    chk("sel_next", int'(sel[id]), pulses[id] % 2);
  endtask

  task automatic check_reset0();
    chk("rst_end_to_prev", int'(etp[0]), 1);
    chk("rst_rd_en", int'(rd[0]), 0);
    chk("rst_rd_addr", int'(ra0), 0);
    chk("rst_first", int'(pf[0]), 0);
    chk("rst_last", int'(pl[0]), 0);
    chk("rst_mode", int'(pm[0]), 0);
    chk("rst_wr_en", int'(we[0]), 0);
    chk("rst_wr_addr", int'(wa0), 0);
    chk("rst_start_next", int'(stn[0]), 0);
    chk("rst_sel", int'(sel[0]), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; mi[i] = 1'b0; efn[i] = 1'b0; end
    cycles(3);
    check_reset0();
    reset = 1'b1;
    cycles(2);
    efn[0] = 1'b1;
    snap(0);
    run_frame(0, 0, 0);
    frame_check(0, 0);
    handoff(0);
    m = int'($urandom_range(0, 1));
    cycles(int'($urandom_range(0, 5)));
    snap(0);
    run_frame(0, m, 1 - m);
    frame_check(0, m);
    handoff(0);
    cycles(int'($urandom_range(0, 5)));
    snap(0);
    run_frame(0, 1 - m, m);
    frame_check(0, 1 - m);
    handoff(0);
    efn[0] = 1'b0;
    snap(0);
    st[0] = 1'b1;
    mi[0] = 1'b0;
    wait_read(0);
    wait_done(0);
    frame_check(0, 0);
    chk("bp_no_pulse", sn[0] - bs, 0);
    snap(0);
    cycles(int'($urandom_range(5, 20)));
    chk("hold_reads", rn[0] - br, 0);
    chk("hold_pulse", sn[0] - bs, 0);
    chk("hold_end_to_prev", int'(etp[0]), 1);
    efn[0] = 1'b1;
    pulses[0]++;
    wait_read(0);
    st[0] = 1'b0;
    chk("bp_pulse", sn[0] - bs, 1);
    if (sn[0] > bs && rn[0] > br) chk("bp_restart_cycle", rcyc[0][br], scyc[0][bs] + 1);
    if (rn[0] > br) chk("bp_restart_addr", radr[0][br], 0);
    chk("bp_sel", int'(sel[0]), pulses[0] % 2);
    bs = bs + 1;
    wait_done(0);
    frame_check(0, 0);
    handoff(0);
    snap(0);
    st[0] = 1'b1;
    mi[0] = 1'b1;
    wait_read(0);
    begin
      int t = 0;
      while (rn[0] - br < 7 && t < 50) begin @(negedge clk); #1; t++; end
    end
    chk("reads_before_reset", rn[0] - br, 7);
    #1 reset = 1'b0;
    #1 check_reset0();
    st[0] = 1'b0;
    cycles(3);
    chk("abandon_pulse", sn[0] - bs, 0);
    reset = 1'b1;
    pulses = '{0, 0, 0};
    cycles(2);
    snap(0);
    run_frame(0, 1, 1);
    frame_check(0, 1);
    handoff(0);
    for (int id = 1; id < 3; id++) begin
      efn[id] = 1'b1;
      for (int f = 0; f < 2; f++) begin
        m = int'($urandom_range(0, 1));
        cycles(int'($urandom_range(0, 4)));
        snap(id);
        run_frame(id, m, 1 - m);
        frame_check(id, m);
        handoff(id);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied, %0d miscompares", vec, bad);
    $fatal(1, "watchdog");
  end
endmodule
